seq_calc_arbiter: RTL

- Round-robin scheduler that shares one Fibonacci/triangle calculator engine (the LOAD_FIB/LOAD_TRI/FIB_ADD/TRI_ADD/OVRFLOW/DONE datapath) among NUM_REQ requesters.
- Accepts one job at a time and issues a start pulse to the engine.
- Watches for completion, with a timeout watchdog.
- Returns result, overflow and error status to the owning requester through a held valid/ready response.

---
 rtl/seq_calc_arbiter_if.sv | 38 +++
 rtl/seq_calc_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_calc_arbiter_if.sv
// Requester, engine and response signals shared between the scheduler and its users.
interface seq_calc_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned N_W     = 8,
  parameter int unsigned RES_W   = 16
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_op;
  logic [NUM_REQ*N_W-1:0] req_n;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   eng_start;
  logic                   eng_op;
  logic [N_W-1:0]         eng_n;
  logic                   eng_abort;
  logic                   eng_done;
  logic [RES_W-1:0]       eng_result;
  logic                   eng_ovf;
  logic                   eng_err;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [RES_W-1:0]       rsp_data;
  logic                   rsp_ovf;
  logic                   rsp_err;
  logic                   rsp_tmo;
  logic                   busy;

  modport slave (
    input  req_valid, req_op, req_n, eng_done, eng_result, eng_ovf, eng_err, rsp_ready,
    output req_ready, eng_start, eng_op, eng_n, eng_abort,
           rsp_valid, rsp_data, rsp_ovf, rsp_err, rsp_tmo, busy
  );

  modport master (
    output req_valid, req_op, req_n, eng_done, eng_result, eng_ovf, eng_err, rsp_ready,
    input  req_ready, eng_start, eng_op, eng_n, eng_abort,
           rsp_valid, rsp_data, rsp_ovf, rsp_err, rsp_tmo, busy
  );
endinterface

// File: rtl/seq_calc_arbiter.sv
// Round-robin scheduler sharing one Fibonacci/triangle engine among NUM_REQ requesters,
// with a WAIT watchdog and a held valid/ready response per job.
module seq_calc_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned N_W     = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset_n,
  seq_calc_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               op_win;
  logic [N_W-1:0]     n_win;
  logic [TMR_W-1:0]   timer;
  logic [NUM_REQ-1:0] grant;
  logic               done_hit;
  logic               tmo_hit;
  logic               accept;

  logic               op_q;
  logic [N_W-1:0]     n_q;
  logic               eng_start_q;
  logic               eng_abort_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [RES_W-1:0]   rsp_data_q;
  logic               rsp_ovf_q;
  logic               rsp_err_q;
  logic               rsp_tmo_q;

  // First valid requester searching upward from rr_ptr, with its operands.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    op_win    = 1'b0;
    n_win     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        op_win = bus.req_op[i];
        n_win  = bus.req_n[i*N_W +: N_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = '0;
    done_hit   = 1'b0;
    tmo_hit    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant[win_id] = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (bus.eng_done) begin
          done_hit   = 1'b1;
          state_next = RESPOND;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        if (bus.rsp_ready[id_q]) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      op_q        <= 1'b0;
      n_q         <= '0;
      timer       <= '0;
      eng_start_q <= 1'b0;
      eng_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      eng_start_q <= (state == IDLE) && win_found;
      eng_abort_q <= tmo_hit;
      busy_q      <= (state_next != IDLE);
      timer       <= (state == WAIT) ? timer + TMR_W'(1) : '0;
      rsp_valid_q <= '0;
      if (state_next == RESPOND) rsp_valid_q[id_q] <= 1'b1;
      if ((state == IDLE) && win_found) begin
        id_q <= win_id;
        op_q <= op_win;
        n_q  <= n_win;
      end
      if (done_hit) begin
        rsp_data_q <= bus.eng_result;
        rsp_ovf_q  <= bus.eng_ovf;
        rsp_err_q  <= bus.eng_err;
        rsp_tmo_q  <= 1'b0;
      end else if (tmo_hit) begin
        rsp_data_q <= '0;
        rsp_ovf_q  <= 1'b0;
        rsp_err_q  <= 1'b1;
        rsp_tmo_q  <= 1'b1;
      end
      if (accept) rr_ptr <= ID_W'((32'(id_q) + 32'd1) % NUM_REQ);
    end
  end

  // Grant is the only combinational output; forced low while reset is held.
  assign bus.req_ready = grant & {NUM_REQ{reset_n}};
  assign bus.eng_start = eng_start_q;
  assign bus.eng_op    = op_q;
  assign bus.eng_n     = n_q;
  assign bus.eng_abort = eng_abort_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tmo   = rsp_tmo_q;
  assign bus.busy      = busy_q;
endmodule
